// File: rtl/a_skew_feeder_if.sv
// Input stream bundle for a_skew_feeder: one A-column beat per accepted cycle.
//   in_valid : upstream has a beat on in_data
//   in_ready : feeder can accept a beat this cycle
//   in_data  : 32*N bits, row r element at [32r+31:32r]
//   in_last  : final beat of the tile, qualified by in_valid
// master = upstream producer, slave = feeder.
interface a_skew_feeder_if #(
  parameter int N = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [32*N-1:0] in_data;
  logic            in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/a_skew_feeder.sv
// a_skew_feeder: turns one A-column beat per cycle into a staircase for a
// systolic PE array. Row r of a beat accepted at the end of cycle t appears on
// a_left row r (with enleft[r]) in cycle t+1+r. Idle slots carry zero data.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_if      : slave side of the input stream (valid/ready/data/last)
//   a_left     : 32*N skewed operands, row r at [32r+31:32r]
//   enleft     : per-row enable paired with a_left
//   busy       : tile in progress or a beat still in the skew chain
//   tile_done  : one-cycle pulse as the tile's last element leaves row N-1
//   beat_cnt   : beats accepted in the current/most recent tile (saturating)
module a_skew_feeder #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  a_skew_feeder_if.slave       in_if,
  output logic [32*N-1:0]      a_left,
  output logic [N-1:0]         enleft,
  output logic                 busy,
  output logic                 tile_done,
  output logic [CNT_W-1:0]     beat_cnt
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam int DCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N - 1);

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic           accept;
  logic [N-1:0]   row_busy;
  logic [N-1:0]   last_sr;

  assign in_if.in_ready = ~rst & (state != DRAIN);
  assign accept         = in_if.in_valid & in_if.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            beat_cnt  <= CNT_W'(1);
            drain_cnt <= '0;
            state     <= in_if.in_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (in_if.in_last) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= IDLE;
          else                         drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Marks the last beat as it walks alongside row N-1's chain, so tile_done
  // lines up with the final enleft[N-1] pulse and dies with a reset.
  always_ff @(posedge clk) begin
    if (rst) last_sr <= '0;
    else     last_sr <= N'({last_sr, accept & in_if.in_last});
  end
  assign tile_done = last_sr[N-1];

  for (genvar r = 0; r < N; r++) begin : g_row
    localparam int EW   = r + 1;
    localparam int DWID = EW * 32;

    logic [EW-1:0]   en_q;
    logic [DWID-1:0] dat_q;
    logic [31:0]     in_elem;

    // Zero-fill non-accepted slots so a_left is 0 whenever enleft is 0.
    assign in_elem = accept ? in_if.in_data[32*r +: 32] : '0;

    // Stage 0 sits at the low end; the concatenation shifts each stage up one.
    always_ff @(posedge clk) begin
      if (rst) begin
        en_q  <= '0;
        dat_q <= '0;
      end else begin
        en_q  <= EW'({en_q, accept});
        dat_q <= DWID'({dat_q, in_elem});
      end
    end

    assign a_left[32*r +: 32] = dat_q[DWID-1 -: 32];
    assign enleft[r]          = en_q[EW-1];
    assign row_busy[r]        = |en_q;
  end

  assign busy = (state != IDLE) | (|row_busy);

endmodule

// File: tb/tb_a_skew_feeder.sv
// Directed bench for a_skew_feeder (N=4). A second instance with CNT_W=2 gets
// the same stimulus to exercise beat_cnt saturation.
module tb_a_skew_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] a_left, a_left_s;
  logic [3:0]   enleft, enleft_s;
  logic         busy, busy_s, tile_done, tile_done_s;
  logic [15:0]  beat_cnt;
  logic [1:0]   beat_cnt_s;

  a_skew_feeder_if #(.N(4)) in_if ();
  a_skew_feeder_if #(.N(4)) sat_if ();

  a_skew_feeder #(.N(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_if(in_if),
    .a_left(a_left), .enleft(enleft), .busy(busy),
    .tile_done(tile_done), .beat_cnt(beat_cnt)
  );

  a_skew_feeder #(.N(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_if(sat_if),
    .a_left(a_left_s), .enleft(enleft_s), .busy(busy_s),
    .tile_done(tile_done_s), .beat_cnt(beat_cnt_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle stimulus and hand-computed expectations (bit c = cycle c).
  logic [15:0]  m_v, m_l, m_r, m_rdy, m_done, m_busy;
  logic [127:0] m_d [16];

  task automatic drive(input logic v, input logic l, input logic [127:0] d);
    in_if.in_valid  = v;  sat_if.in_valid = v;
    in_if.in_last   = l;  sat_if.in_last  = l;
    in_if.in_data   = d;  sat_if.in_data  = d;
  endtask

  task automatic clear_vectors();
    m_v = '0; m_l = '0; m_r = '0; m_rdy = '0; m_done = '0; m_busy = '0;
    for (int i = 0; i < 16; i++) m_d[i] = '0;
  endtask

  // Runs ncyc cycles; the skewed data/enables come from a history of beats the
  // bench expects to be accepted (valid and expected-ready).
  task automatic run(input string name, input int ncyc, input int cnt0,
                     input int mid_c, input int cnt_mid, input int cnt_end,
                     input int sat_end);
    logic         hv [16];
    logic [127:0] hd [16];
    logic [127:0] exp_a;
    logic [3:0]   exp_en;
    int           s;
    for (int i = 0; i < 16; i++) begin hv[i] = 1'b0; hd[i] = '0; end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst = m_r[c];
      drive(m_v[c], m_l[c], m_d[c]);
      #1;
      exp_a  = '0;
      exp_en = '0;
      for (int r = 0; r < 4; r++) begin
        s = c - 1 - r;
        if (s >= 0 && hv[s]) begin
          exp_en[r]         = 1'b1;
          exp_a[32*r +: 32] = hd[s][32*r +: 32];
        end
      end
      check($sformatf("%s c%0d enleft", name, c), enleft, exp_en);
      check($sformatf("%s c%0d a_left", name, c), a_left, exp_a);
      check($sformatf("%s c%0d tile_done", name, c), tile_done, m_done[c]);
      check($sformatf("%s c%0d in_ready", name, c), in_if.in_ready, m_rdy[c]);
      check($sformatf("%s c%0d busy", name, c), busy, m_busy[c]);
      if (c == 0)
        check($sformatf("%s c%0d beat_cnt", name, c), beat_cnt, cnt0);
      if (c == mid_c)
        check($sformatf("%s c%0d beat_cnt", name, c), beat_cnt, cnt_mid);
      if (c == ncyc - 1) begin
        check($sformatf("%s c%0d beat_cnt", name, c), beat_cnt, cnt_end);
        check($sformatf("%s c%0d sat beat_cnt", name, c), beat_cnt_s, sat_end);
        check($sformatf("%s c%0d sat tile_done", name, c), tile_done_s, m_done[c]);
      end
      hv[c] = m_v[c] & m_rdy[c];
      hd[c] = m_d[c];
      if (m_r[c]) for (int j = 0; j <= c; j++) hv[j] = 1'b0;
    end
  endtask

  task automatic single_beat(input string name, input int cnt0);
    clear_vectors();
    m_v = 16'h0001; m_l = 16'h0001;
    m_d[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    m_rdy = 16'h0021; m_done = 16'h0010; m_busy = 16'h001E;
    run(name, 6, cnt0, 1, 1, 1, 1);
  endtask

  initial begin
    drive(1'b0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst in_ready", in_if.in_ready, 1'b0);
    @(negedge clk); #1;
    check("rst in_ready2", in_if.in_ready, 1'b0);
    check("rst a_left", a_left, '0);
    check("rst enleft", enleft, '0);
    check("rst tile_done", tile_done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst beat_cnt", beat_cnt, '0);

    // Single beat with in_last
    single_beat("single", 0);

    // Three back-to-back beats, same value on every row
    clear_vectors();
    m_v = 16'h0007; m_l = 16'h0004;
    m_d[0] = {4{32'h10}}; m_d[1] = {4{32'h20}}; m_d[2] = {4{32'h30}};
    m_rdy = 16'h0087; m_done = 16'h0040; m_busy = 16'h007E;
    run("b2b", 8, 1, 1, 1, 3, 3);

    // Bubble in cycle 1 carrying garbage data and a stray in_last
    clear_vectors();
    m_v = 16'h0005; m_l = 16'h0006;
    m_d[0] = {32'h13, 32'h12, 32'h11, 32'h10};
    m_d[1] = {4{32'hDEADBEEF}};
    m_d[2] = {32'h33, 32'h32, 32'h31, 32'h30};
    m_rdy = 16'h0087; m_done = 16'h0040; m_busy = 16'h007E;
    run("bubble", 8, 3, 1, 1, 2, 2);

    // Reset during DRAIN: no tile_done, reset values afterwards
    clear_vectors();
    m_v = 16'h0001; m_l = 16'h0001; m_r = 16'h0004;
    m_d[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    m_rdy = 16'h0079; m_done = 16'h0000; m_busy = 16'h0006;
    run("rst_drain", 7, 2, 1, 1, 0, 0);
    single_beat("post_rst", 0);

    // Back-to-back tiles with in_valid held high across tile_done
    clear_vectors();
    m_v = 16'h03FF; m_l = 16'h0201;
    for (int c = 0; c < 16; c++)
      m_d[c] = {32'hA000_0003 + 32'(c*16), 32'hA000_0002 + 32'(c*16),
                32'hA000_0001 + 32'(c*16), 32'hA000_0000 + 32'(c*16)};
    m_rdy = 16'h43E1; m_done = 16'h2010; m_busy = 16'h3FDE;
    run("tiles_sat", 15, 1, 6, 1, 5, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
